// File: rtl/dht11_frame_reader.sv
`timescale 1ns/1ps
// DHT11 single-wire reader: drives the host start pulse, follows the sensor
// response handshake and decodes 40 data bits by the width of each high pulse.
//
// state     | meaning
// IDLE      | bus released, waiting for start
// START_LOW | host holds bus low for START_LOW_US
// WAIT_RESP | bus released, waiting for sensor to pull low
// RESP_LOW  | sensor response low phase
// RESP_HIGH | sensor response high phase
// BIT_LOW   | low preamble of a data bit
// BIT_HIGH  | data-high pulse being timed
// DONE      | publish frame and checksum
// ERR       | report timeout
module dht11_frame_reader #(
    parameter int CYC_PER_US    = 25,
    parameter int START_LOW_US  = 18000,
    parameter int TIMEOUT_US    = 200,
    parameter int BIT_THRESH_US = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        dht11_data,
    output logic        dht11_oe,
    output logic        busy,
    output logic [39:0] frame,
    output logic        frame_valid,
    output logic        checksum_ok,
    output logic        timeout_err
);
    localparam int PHASE_MAX = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
    localparam int PHASE_W   = $clog2(PHASE_MAX + 2);
    localparam int PRE_W     = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;

    typedef enum logic [3:0] {
        IDLE, START_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, DONE, ERR
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q, prev_q;
    logic [PRE_W-1:0]     presc_q, presc_d;
    logic [PHASE_W-1:0]   phase_q, phase_d, phase_next;
    logic [5:0]           idx_q, idx_d;
    logic [39:0]          shift_q, shift_d, frame_q, frame_d;
    logic                 checksum_ok_q, checksum_ok_d;
    logic                 frame_valid_q, frame_valid_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 us_tick, rise, fall, timeout_hit;
    logic [7:0]           byte_sum;

    assign rise        = sync2_q & ~prev_q;
    assign fall        = ~sync2_q & prev_q;
    assign us_tick     = (presc_q == PRE_W'(CYC_PER_US - 1));
    // Elapsed time including the current cycle, so a pulse of N us reads as N.
    assign phase_next  = phase_q + PHASE_W'(us_tick);
    assign timeout_hit = (phase_next >= PHASE_W'(TIMEOUT_US));
    assign byte_sum    = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        idx_d         = idx_q;
        frame_d       = frame_q;
        checksum_ok_d = checksum_ok_q;
        frame_valid_d = 1'b0;
        timeout_err_d = 1'b0;
        presc_d       = '0;
        phase_d       = '0;

        unique case (state_q)
            IDLE: begin
                if (start) state_d = START_LOW;
            end
            START_LOW: begin
                if (phase_next >= PHASE_W'(START_LOW_US)) state_d = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (fall)             state_d = RESP_LOW;
                else if (timeout_hit) state_d = ERR;
            end
            RESP_LOW: begin
                if (rise)             state_d = RESP_HIGH;
                else if (timeout_hit) state_d = ERR;
            end
            RESP_HIGH: begin
                if (fall) begin
                    state_d = BIT_LOW;
                    idx_d   = '0;
                end else if (timeout_hit) begin
                    state_d = ERR;
                end
            end
            BIT_LOW: begin
                if (rise)             state_d = BIT_HIGH;
                else if (timeout_hit) state_d = ERR;
            end
            BIT_HIGH: begin
                if (fall) begin
                    shift_d = {shift_q[38:0], (phase_next >= PHASE_W'(BIT_THRESH_US))};
                    if (idx_q == 6'd39) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = BIT_LOW;
                    end
                end else if (timeout_hit) begin
                    state_d = ERR;
                end
            end
            DONE: begin
                frame_d       = shift_q;
                checksum_ok_d = (byte_sum == shift_q[7:0]);
                frame_valid_d = 1'b1;
                state_d       = IDLE;
            end
            ERR: begin
                timeout_err_d = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == state_q && state_q != IDLE) begin
            presc_d = us_tick ? '0 : presc_q + PRE_W'(1);
            phase_d = phase_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            prev_q        <= 1'b1;
            presc_q       <= '0;
            phase_q       <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            frame_q       <= '0;
            checksum_ok_q <= 1'b0;
            frame_valid_q <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= dht11_data;
            sync2_q       <= sync1_q;
            prev_q        <= sync2_q;
            presc_q       <= presc_d;
            phase_q       <= phase_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            frame_q       <= frame_d;
            checksum_ok_q <= checksum_ok_d;
            frame_valid_q <= frame_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign dht11_oe    = (state_q == START_LOW);
    assign busy        = (state_q != IDLE);
    assign frame       = frame_q;
    assign frame_valid = frame_valid_q;
    assign checksum_ok = checksum_ok_q;
    assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_dht11_frame_reader.sv
`timescale 1ns/1ps
// Bench for dht11_frame_reader: a timed sensor model plays frames built from
// per-bit high widths; expectations come from the widths and byte arithmetic.
module tb_dht11_frame_reader;
    localparam int C  = 2;
    localparam int S  = 50;
    localparam int T  = 200;
    localparam int TH = 50;

    logic        clk = 1'b0;
    logic        rst, start, dht11_data;
    logic        dht11_oe, busy, frame_valid, checksum_ok, timeout_err;
    logic [39:0] frame;

    int n_assert = 0;
    int n_fail   = 0;
    int fv_cnt   = 0;
    int to_cnt   = 0;
    int widths[40];

    dht11_frame_reader #(
        .CYC_PER_US(C), .START_LOW_US(S), .TIMEOUT_US(T), .BIT_THRESH_US(TH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .dht11_data(dht11_data),
        .dht11_oe(dht11_oe), .busy(busy), .frame(frame), .frame_valid(frame_valid),
        .checksum_ok(checksum_ok), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_cnt <= fv_cnt + 1;
        if (timeout_err === 1'b1) to_cnt <= to_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic lvl, input int us);
        dht11_data = lvl;
        tick(us * C);
    endtask

    // Reference: a bit is 1 when its high pulse lasts at least TH us.
    function automatic logic [39:0] model_frame();
        logic [39:0] f;
        for (int i = 0; i < 40; i++) f[39-i] = (widths[i] >= TH);
        return f;
    endfunction

    function automatic logic model_csum(input logic [39:0] f);
        int s;
        s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
        return (s % 256) == int'(f[7:0]);
    endfunction

    task automatic widths_from_bits(input logic [39:0] f);
        for (int i = 0; i < 40; i++)
            widths[i] = f[39-i] ? int'($urandom_range(62, 75)) : int'($urandom_range(22, 30));
    endtask

    task automatic do_start(output int width);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        width = 0;
        while (dht11_oe === 1'b1 && width < S * C + 20) begin
            tick(1);
            width++;
        end
    endtask

    task automatic sensor(input int rst_bit, input int start_bit);
        hold(1'b1, 20);
        hold(1'b0, 80);
        hold(1'b1, 80);
        for (int i = 0; i < 40; i++) begin
            if (i == rst_bit) begin
                hold(1'b0, 10);
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
                dht11_data = 1'b1;
                check("rst_mid_oe", dht11_oe, 1'b0);
                check("rst_mid_busy", busy, 1'b0);
                return;
            end
            if (i == start_bit) begin
                dht11_data = 1'b0;
                tick(20 * C);
                start = 1'b1;
                tick(1);
                start = 1'b0;
                check("start_ignored_oe", dht11_oe, 1'b0);
                check("start_ignored_busy", busy, 1'b1);
                tick(30 * C - 1);
            end else begin
                hold(1'b0, 50);
            end
            hold(1'b1, widths[i]);
        end
        hold(1'b0, 50);
        dht11_data = 1'b1;
    endtask

    task automatic read_frame(input string tag, input int rst_bit, input int start_bit);
        int w;
        do_start(w);
        check({tag, "_oe_width_ok"}, (w >= S * C - C) && (w <= S * C + C), 1'b1);
        sensor(rst_bit, start_bit);
        tick(10);
    endtask

    task automatic frame_test(input string tag);
        logic [39:0] ef;
        int fv0, to0;
        ef  = model_frame();
        fv0 = fv_cnt;
        to0 = to_cnt;
        read_frame(tag, -1, -1);
        check({tag, "_fv_count"}, fv_cnt - fv0, 1);
        check({tag, "_to_count"}, to_cnt - to0, 0);
        check({tag, "_frame"}, frame, ef);
        check({tag, "_csum"}, checksum_ok, model_csum(ef));
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [39:0] f;
        logic [39:0] ftmp;
        int n, fv0, to0;

        rst = 1'b1;
        start = 1'b0;
        dht11_data = 1'b1;
        tick(3);
        check("rst_frame", frame, 40'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_oe", dht11_oe, 1'b0);
        check("rst_fv", frame_valid, 1'b0);
        check("rst_csum", checksum_ok, 1'b0);
        check("rst_to", timeout_err, 1'b0);
        rst = 1'b0;
        tick(5);

        widths_from_bits(40'h370018004F);
        frame_test("good");
        check("good_const", frame, 40'h370018004F);
        check("good_csum_const", checksum_ok, 1'b1);

        // Stray bus activity while idle must not start anything.
        fv0 = fv_cnt;
        for (int i = 0; i < 4; i++) begin
            hold(1'b0, 30);
            hold(1'b1, 40);
        end
        check("idle_edges_busy", busy, 1'b0);
        check("idle_edges_fv", fv_cnt - fv0, 0);

        widths_from_bits(40'h3700180050);
        frame_test("badsum");
        check("badsum_const", frame, 40'h3700180050);
        check("badsum_csum_const", checksum_ok, 1'b0);

        // No response: line stays high after the start pulse.
        fv0 = fv_cnt;
        to0 = to_cnt;
        do_start(n);
        check("to_oe_width_ok", (n >= S * C - C) && (n <= S * C + C), 1'b1);
        n = 0;
        while (timeout_err !== 1'b1 && n < T * C + 50) begin
            tick(1);
            n++;
        end
        check("to_latency_ok", (n >= T * C - C) && (n <= T * C + C + 2), 1'b1);
        check("to_busy", busy, 1'b0);
        tick(3);
        check("to_count", to_cnt - to0, 1);
        check("to_no_fv", fv_cnt - fv0, 0);
        check("to_frame_kept", frame, 40'h3700180050);
        check("to_csum_kept", checksum_ok, 1'b0);

        // Width threshold boundaries.
        widths[0] = 26; widths[1] = 49; widths[2] = 50; widths[3] = 70;
        for (int i = 4; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: widths[i] = 26;
                1: widths[i] = 49;
                2: widths[i] = 50;
                default: widths[i] = 70;
            endcase
        end
        frame_test("thresh");
        ftmp = frame;
        check("thresh_first4", ftmp[39:36], 4'b0011);

        f[39:8] = $urandom;
        f[7:0]  = f[39:32] + f[31:24] + f[23:16] + f[15:8] + 8'($urandom_range(0, 1));
        widths_from_bits(f);
        frame_test("rand");
        check("rand_bits", frame, f);

        // Start pulse during a bit, then reset mid-frame.
        f[39:8] = $urandom;
        f[7:0]  = $urandom;
        widths_from_bits(f);
        fv0 = fv_cnt;
        to0 = to_cnt;
        read_frame("abort", 20, 5);
        tick(50);
        check("abort_no_fv", fv_cnt - fv0, 0);
        check("abort_no_to", to_cnt - to0, 0);
        check("abort_busy", busy, 1'b0);
        check("abort_oe", dht11_oe, 1'b0);
        check("abort_frame_cleared", frame, 40'h0);

        f[39:8] = $urandom;
        f[7:0]  = f[39:32] + f[31:24] + f[23:16] + f[15:8];
        widths_from_bits(f);
        frame_test("after_rst");
        check("after_rst_bits", frame, f);
        check("after_rst_csum", checksum_ok, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
